// File: rtl/regfile_dump_if.sv
// Bus bundle for regfile_dump: the two regfile read ports plus the valid/ready dump stream.
// master = sequencer side, slave = regfile/downstream side.
interface regfile_dump_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] rd1_addr;
    logic [DATA_W-1:0] rd1_data;
    logic [ADDR_W-1:0] rd2_addr;
    logic [DATA_W-1:0] rd2_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_idx;
    logic [DATA_W-1:0] out_data;
    logic              out_sum;
    logic              out_last;

    modport master (
        output rd1_addr, rd2_addr, out_valid, out_idx, out_data, out_sum, out_last,
        input  rd1_data, rd2_data, out_ready
    );

    modport slave (
        input  rd1_addr, rd2_addr, out_valid, out_idx, out_data, out_sum, out_last,
        output rd1_data, rd2_data, out_ready
    );
endinterface

// File: rtl/regfile_dump.sv
// Debug sequencer that reads the regfile two registers per fetch and streams them out.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum beat after the last register.
module regfile_dump #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned REG_COUNT = 32,
    localparam int unsigned ADDR_W   = $clog2(REG_COUNT)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    regfile_dump_if.master bus
);
    typedef enum logic [2:0] {StIdle, StFetch, StDrain0, StDrain1, StSum, StDone} state_e;

    localparam logic [ADDR_W-1:0] LastBase = ADDR_W'(REG_COUNT - 2);

    state_e            state_q, state_d;
    // Even index 2k of the current pair; read addresses follow it so they hold outside FETCH.
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;
    logic              hs;
    logic              last_pair;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] xor_q, xor_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            base_q  <= '0;
            buf0_q  <= '0;
            buf1_q  <= '0;
`ifdef REGDUMP_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
`ifdef REGDUMP_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign hs        = bus.out_valid & bus.out_ready;
    assign last_pair = (base_q == LastBase);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
`ifdef REGDUMP_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = '0;
`ifdef REGDUMP_CHECKSUM_EN
                    xor_d   = '0;
`endif
                    state_d = StFetch;
                end
            end
            StFetch: begin
                buf0_d  = bus.rd1_data;
                buf1_d  = bus.rd2_data;
                state_d = StDrain0;
            end
            StDrain0: begin
                if (hs) begin
`ifdef REGDUMP_CHECKSUM_EN
                    xor_d = xor_q ^ buf0_q;
`endif
                    state_d = StDrain1;
                end
            end
            StDrain1: begin
                if (hs) begin
`ifdef REGDUMP_CHECKSUM_EN
                    xor_d = xor_q ^ buf1_q;
`endif
                    if (last_pair) begin
`ifdef REGDUMP_CHECKSUM_EN
                        state_d = StSum;
`else
                        state_d = StDone;
`endif
                    end else begin
                        base_d  = base_q + ADDR_W'(2);
                        state_d = StFetch;
                    end
                end
            end
            StSum: begin
                if (hs) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.rd1_addr  = base_q;
        bus.rd2_addr  = base_q | ADDR_W'(1);
        bus.out_valid = 1'b0;
        bus.out_idx   = '0;
        bus.out_data  = '0;
        bus.out_sum   = 1'b0;
        bus.out_last  = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (state_q)
            StFetch: busy = 1'b1;
            StDrain0: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_idx   = base_q;
                bus.out_data  = buf0_q;
            end
            StDrain1: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_idx   = base_q | ADDR_W'(1);
                bus.out_data  = buf1_q;
`ifndef REGDUMP_CHECKSUM_EN
                bus.out_last  = last_pair;
`endif
            end
            StSum: begin
`ifdef REGDUMP_CHECKSUM_EN
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_data  = xor_q;
                bus.out_sum   = 1'b1;
                bus.out_last  = 1'b1;
`endif
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: a behavioural regfile feeds the read ports and the stream
// is captured per beat and compared against hand-computed register contents.
module tb_regfile_dump;
    localparam int DW = 64;
    localparam int RC = 32;
    localparam int AW = 5;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int NBEATS    = RC + 1;
    localparam int LAST_DATA = -1;
`else
    localparam int NBEATS    = RC;
    localparam int LAST_DATA = RC - 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done;
    logic [DW-1:0] regs [RC];

    regfile_dump_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    assign bus.rd1_data = regs[bus.rd1_addr];
    assign bus.rd2_data = regs[bus.rd2_addr];

    regfile_dump #(.DATA_W(DW), .REG_COUNT(RC)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .busy (busy),
        .done (done),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] q_idx[$];
    logic [DW-1:0] q_data[$];
    logic          q_sum[$];
    logic          q_last[$];
    int busy_cyc, done_cnt, done_cyc, last_hs_cyc, stable_err, timed_out;

    function automatic logic [DW-1:0] seq_val(input int i);
        if (i == 0) return 64'hDEADBEEFCAFEBABE;
        if (i == 1) return 64'h0123456789ABCDEF;
        return DW'(i);
    endfunction

    task automatic preload_seq();
        for (int i = 0; i < RC; i++) regs[i] = seq_val(i);
    endtask

    // Runs one dump and records beats; cycle 1 is the first cycle after start is sampled.
    task automatic run_dump(input int ready_pct, input int extra_start, input int wr_cyc);
        int c;
        logic stall;
        logic [AW-1:0] s_idx;
        logic [DW-1:0] s_data;
        logic s_sum, s_last;
        q_idx.delete(); q_data.delete(); q_sum.delete(); q_last.delete();
        busy_cyc = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
        stable_err = 0; timed_out = 0; stall = 1'b0;
        s_idx = '0; s_data = '0; s_sum = 1'b0; s_last = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        bus.out_ready = 1'b1;
        c = 0;
        while (1) begin
            @(posedge clk); #1;
            c++;
            start = (c == extra_start);
            if (c == wr_cyc) regs[20] = 64'hAA;
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (stall && (!bus.out_valid || bus.out_idx !== s_idx || bus.out_data !== s_data ||
                          bus.out_sum !== s_sum || bus.out_last !== s_last)) stable_err++;
            bus.out_ready = ($urandom_range(99) < ready_pct);
            if (bus.out_valid && bus.out_ready) begin
                q_idx.push_back(bus.out_idx);
                q_data.push_back(bus.out_data);
                q_sum.push_back(bus.out_sum);
                q_last.push_back(bus.out_last);
                last_hs_cyc = c;
            end
            stall  = bus.out_valid && !bus.out_ready;
            s_idx  = bus.out_idx;
            s_data = bus.out_data;
            s_sum  = bus.out_sum;
            s_last = bus.out_last;
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
            if (c >= 2000) begin
                timed_out = 1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < RC; i++) regs[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_sum !== 1'b0 ||
            bus.out_last !== 1'b0 || bus.out_idx !== '0 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b valid=%b sum=%b last=%b idx=%0d data=%h want all 0",
                     busy, done, bus.out_valid, bus.out_sum, bus.out_last, bus.out_idx,
                     bus.out_data);
        end
        checks++;
        if (bus.rd1_addr !== 5'd0 || bus.rd2_addr !== 5'd1) begin
            errors++;
            $display("FAIL reset_addr rd1=%0d rd2=%0d want 0 1", bus.rd1_addr, bus.rd2_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [DW-1:0] x;
        preload_seq();
        run_dump(100, -1, -1);
        checks++;
        if (timed_out != 0 || q_idx.size() != NBEATS) begin
            errors++;
            $display("FAIL seq_count beats=%0d timeout=%0d want %0d", q_idx.size(), timed_out,
                     NBEATS);
        end
        x = '0;
        for (int i = 0; i < RC; i++) begin
            x ^= seq_val(i);
            checks++;
            if (i >= q_idx.size()) begin
                errors++;
                $display("FAIL seq_beat%0d missing", i);
            end else if (q_idx[i] !== AW'(i) || q_data[i] !== seq_val(i) || q_sum[i] !== 1'b0 ||
                         q_last[i] !== (i == LAST_DATA)) begin
                errors++;
                $display("FAIL seq_beat%0d idx=%0d data=%h sum=%b last=%b want idx=%0d data=%h",
                         i, q_idx[i], q_data[i], q_sum[i], q_last[i], i, seq_val(i));
            end
        end
`ifdef REGDUMP_CHECKSUM_EN
        checks++;
        if (q_idx.size() < NBEATS || q_sum[RC] !== 1'b1 || q_last[RC] !== 1'b1 ||
            q_idx[RC] !== '0 || q_data[RC] !== x) begin
            errors++;
            $display("FAIL seq_sum_beat want sum=1 last=1 idx=0 data=%h", x);
        end
`endif
        checks++;
        if (busy_cyc != 3 * RC / 2 + NBEATS - RC) begin
            errors++;
            $display("FAIL seq_busy_cycles got %0d want %0d", busy_cyc, 3 * RC / 2 + NBEATS - RC);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
            errors++;
            $display("FAIL seq_done count=%0d at=%0d last_hs=%0d want 1 at last_hs+1",
                     done_cnt, done_cyc, last_hs_cyc);
        end
    endtask

    task automatic test_backpressure();
        preload_seq();
        run_dump(30, -1, -1);
        checks++;
        if (timed_out != 0 || q_idx.size() != NBEATS) begin
            errors++;
            $display("FAIL bp_count beats=%0d timeout=%0d want %0d", q_idx.size(), timed_out,
                     NBEATS);
        end
        for (int i = 0; i < RC; i++) begin
            checks++;
            if (i >= q_idx.size()) begin
                errors++;
                $display("FAIL bp_beat%0d missing", i);
            end else if (q_idx[i] !== AW'(i) || q_data[i] !== seq_val(i) ||
                         q_last[i] !== (i == LAST_DATA)) begin
                errors++;
                $display("FAIL bp_beat%0d idx=%0d data=%h want idx=%0d data=%h",
                         i, q_idx[i], q_data[i], i, seq_val(i));
            end
        end
        checks++;
        if (stable_err != 0) begin
            errors++;
            $display("FAIL bp_stable unstable_stalls=%0d want 0", stable_err);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
            errors++;
            $display("FAIL bp_done count=%0d at=%0d last_hs=%0d want 1 at last_hs+1",
                     done_cnt, done_cyc, last_hs_cyc);
        end
    endtask

    task automatic test_start_while_busy();
        preload_seq();
        run_dump(100, 10, -1);
        checks++;
        if (q_idx.size() != NBEATS || q_idx[0] !== '0 || q_idx[RC-1] !== AW'(RC - 1)) begin
            errors++;
            $display("FAIL swb_beats count=%0d want %0d in order", q_idx.size(), NBEATS);
        end
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL swb_done count=%0d busy_after=%b want 1 0", done_cnt, busy);
        end
    endtask

    task automatic test_mid_reset();
        int dn;
        preload_seq();
        @(posedge clk); #1;
        start = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_idx !== 5'd9) begin
            errors++;
            $display("FAIL mr_pos valid=%b idx=%0d want 1 9", bus.out_valid, bus.out_idx);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.out_last !== 1'b0 ||
            bus.rd1_addr !== 5'd0 || bus.rd2_addr !== 5'd1) begin
            errors++;
            $display("FAIL mr_after valid=%b busy=%b done=%b last=%b rd1=%0d rd2=%0d want 0 0 0 0 0 1",
                     bus.out_valid, busy, done, bus.out_last, bus.rd1_addr, bus.rd2_addr);
        end
        dn = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done || busy || bus.out_valid) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL mr_quiet active_cycles=%0d want 0", dn);
        end
        run_dump(100, -1, -1);
        checks++;
        if (q_idx.size() != NBEATS || q_idx[0] !== '0 || q_data[0] !== seq_val(0) ||
            done_cnt != 1) begin
            errors++;
            $display("FAIL mr_restart beats=%0d done=%0d want %0d beats from idx 0, 1 done",
                     q_idx.size(), done_cnt, NBEATS);
        end
    endtask

    task automatic test_concurrent_write();
        preload_seq();
        run_dump(100, -1, 15);
        checks++;
        if (q_idx.size() != NBEATS || q_idx[20] !== 5'd20 || q_data[20] !== 64'hAA) begin
            errors++;
            $display("FAIL cw_r20 idx=%0d data=%h want 20 00000000000000aa", q_idx[20],
                     q_data[20]);
        end
        checks++;
        if (q_data[2] !== 64'd2 || q_data[21] !== 64'd21) begin
            errors++;
            $display("FAIL cw_neighbours r2=%h r21=%h want 2 21", q_data[2], q_data[21]);
        end
    endtask

`ifdef REGDUMP_CHECKSUM_EN
    task automatic test_checksum();
        for (int i = 0; i < RC; i++) regs[i] = '0;
        regs[0] = 64'd5;
        regs[1] = 64'd3;
        run_dump(100, -1, -1);
        checks++;
        if (q_idx.size() != 33) begin
            errors++;
            $display("FAIL cs_count beats=%0d want 33", q_idx.size());
        end else if (q_sum[32] !== 1'b1 || q_idx[32] !== '0 || q_data[32] !== 64'd6 ||
                     q_last[32] !== 1'b1) begin
            errors++;
            $display("FAIL cs_beat sum=%b idx=%0d data=%h last=%b want 1 0 6 1",
                     q_sum[32], q_idx[32], q_data[32], q_last[32]);
        end
        checks++;
        if (q_idx.size() == 33 && (q_last[31] !== 1'b0 || q_sum[31] !== 1'b0)) begin
            errors++;
            $display("FAIL cs_idx31 last=%b sum=%b want 0 0", q_last[31], q_sum[31]);
        end
    endtask
`endif

    initial begin
        bus.out_ready = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_start_while_busy();
        test_mid_reset();
        test_concurrent_write();
`ifdef REGDUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_dump.md
# regfile_dump

Read-side debug sequencer for `regfile`. On a start pulse it walks every architectural register through the two regfile read ports, two registers per fetch. It then streams each value out one per beat on a valid/ready interface, tagged with its index. It sits beside the regfile as the read counterpart to the bench/debug writer, and feeds the trace/debug link.

## Interface
- `DATA_W`, 64, register width
- `REG_COUNT`, 32, registers dumped; must be even and ≥2
- `ADDR_W`, `$clog2(REG_COUNT)`, index width (derived; do not override)

- `clk` in 1: sole clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: request a dump; sampled only in IDLE
- `busy` out 1: high from the first FETCH cycle until the last beat handshakes
- `done` out 1: one-cycle pulse after the dump completes
- `rd1_addr` out ADDR_W: regfile read port 1 address
- `rd1_data` in DATA_W: regfile read port 1 data (combinational read)
- `rd2_addr` out ADDR_W: regfile read port 2 address
- `rd2_data` in DATA_W: regfile read port 2 data (combinational read)
- `out_valid` out 1: beat valid
- `out_ready` in 1: downstream accept
- `out_idx` out ADDR_W: register index of the beat
- `out_data` out DATA_W: register value
- `out_sum` out 1: beat is the checksum beat
- `out_last` out 1: final beat of the dump

## Operation
- FSM states: IDLE, FETCH, DRAIN0, DRAIN1, SUM, DONE.
- IDLE: if `start`=1, clear pair counter `k` and go to FETCH. Otherwise stay.
- FETCH (1 cycle):
  - `rd1_addr`=2k, `rd2_addr`=2k+1.
  - Capture `rd1_data` into buf0 and `rd2_data` into buf1 at the clock edge.
  - Go to DRAIN0.
- DRAIN0: present buf0 with `out_idx`=2k. On handshake go to DRAIN1.
- DRAIN1: present buf1 with `out_idx`=2k+1. On handshake:
  - If 2k+1 < REG_COUNT−1: k←k+1, go to FETCH.
  - Otherwise go to SUM if the checksum feature is compiled in, else DONE.
- SUM: present `out_data`=running XOR, `out_idx`=0, `out_sum`=1. On handshake go to DONE.
- DONE: `done`=1, `busy`=0. Next cycle go to IDLE.
- Handshake means `out_valid` & `out_ready` at a rising edge.
  - While `out_valid`=1 and `out_ready`=0, all out_* fields hold stable.
  - `out_valid` never drops without a handshake.
- Consistency: each pair is sampled at its FETCH cycle. Writes landing between fetches are visible to later pairs; no whole-file snapshot.
- `start` while not IDLE is ignored. It is not queued.
- `rd*_addr` hold their last value outside FETCH.
- `rst` at any time: state→IDLE and all outputs to reset values. Any beat in flight is dropped with no `out_last` or `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_sum`=0, `out_last`=0, `out_idx`=0, `out_data`=0, `rd1_addr`=0, `rd2_addr`=1.
- `start` sampled at edge 0 → FETCH in cycle 1 (`busy`=1) → `out_valid`=1 from cycle 2.
- With `out_ready` tied 1:
  - 3 cycles per register pair.
  - Dump length 3·REG_COUNT/2 cycles, plus 1 cycle for SUM if enabled.
  - `done` follows the final handshake by exactly 1 cycle.
- `out_last`=1 only on the final beat: idx REG_COUNT−1 without checksum, or the SUM beat with it.
- `busy` falls in the DONE cycle, coincident with `done`.

## Configuration
- `REGDUMP_CHECKSUM_EN` defined:
  - A running XOR of all dumped values is cleared in IDLE on `start` and updated on each DRAIN handshake.
  - The extra SUM beat is emitted and carries `out_last`.
- Not defined:
  - No XOR register is built and the SUM state is unreachable.
  - `out_sum` is tied 0.
  - `out_last` marks idx REG_COUNT−1.

## Test plan
- Sequential dump: preload r0=64'hDEADBEEFCAFEBABE, r1=64'h0123456789ABCDEF, rN=N for N≥2. Pulse `start` with `out_ready`=1.
  - Expect 32 beats, idx 0..31 in order, matching values.
  - Expect `out_last` on idx 31 (macro off), `done` 1 cycle later, 48 busy cycles.
- Backpressure: randomly toggle `out_ready` at 30% high.
  - Expect identical beat sequence.
  - Expect fields stable whenever valid && !ready.
  - Expect no lost or duplicated index.
- Checksum (macro on): preload r0=5, r1=3, all others 0.
  - Expect 33 beats; the final beat has `out_sum`=1, `out_idx`=0, `out_data`=6, `out_last`=1.
- Start while busy: pulse `start` at cycle 10 of a dump.
  - Expect the dump unaffected and exactly one `done`.
- Mid-dump reset: assert `rst` during DRAIN1 of pair k=4.
  - Expect `out_valid`=0 and `busy`=0 next cycle, no `done`.
  - A new `start` restarts from idx 0.
- Concurrent write: write r20=64'hAA after pair 2 is fetched but before pair 10 is fetched.
  - Expect idx 20 to carry 64'hAA.
